// File: rtl/pop_timing_pkg.sv
// Shared mode codes, sequencer state encoding and default timing for the POP mode sequencer.
package pop_timing_pkg;

    localparam int DEBOUNCE_SAMPLES_DEFAULT = 8;
    localparam int GUARD_CYCLES_DEFAULT     = 16;

    typedef enum logic [1:0] {
        MODE_SETUP = 2'd0,
        MODE_POP   = 2'd1,
        MODE_DARK  = 2'd2,
        MODE_CAL   = 2'd3
    } mode_e;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_GUARD = 1'b1
    } seq_state_e;

    typedef struct packed {
        logic led;
        logic pump;
        logic probe;
        logic mw;
        logic sample;
    } drive_t;

    localparam drive_t DRIVE_OFF = '0;

    // CAL wraps back to SETUP through the natural 2-bit overflow.
    function automatic mode_e next_mode(input mode_e m);
        return mode_e'(m + 2'd1);
    endfunction

endpackage

// File: rtl/pop_mode_sequencer_if.sv
// Button, POP timer channels and drive outputs of the mode sequencer as one bundle.
interface pop_mode_sequencer_if;

    logic       mode_button;
    logic       tick_100us;
    logic       slow_pulse;
    logic       fast_pulse;
    logic       cycle_start;
    logic       pump_in;
    logic       probe_in;
    logic       mw_in;
    logic       sample_in;
    logic       pop_enable;
    logic       led_out;
    logic       pump_out;
    logic       probe_out;
    logic       mw_out;
    logic       sample_out;
    logic [1:0] mode;

    modport master (
        output mode_button, tick_100us, slow_pulse, fast_pulse, cycle_start,
               pump_in, probe_in, mw_in, sample_in,
        input  pop_enable, led_out, pump_out, probe_out, mw_out, sample_out, mode
    );

    modport slave (
        input  mode_button, tick_100us, slow_pulse, fast_pulse, cycle_start,
               pump_in, probe_in, mw_in, sample_in,
        output pop_enable, led_out, pump_out, probe_out, mw_out, sample_out, mode
    );

endinterface

// File: rtl/button_debouncer.sv
// Synchronizes the raw mode button, debounces it on the sample tick and emits a
// one-clk strobe on each accepted released-to-pressed transition.
module button_debouncer
    import pop_timing_pkg::*;
#(
    parameter int DEBOUNCE_SAMPLES = DEBOUNCE_SAMPLES_DEFAULT
) (
    input  logic clk,
    input  logic reset_n,
    input  logic button_raw,
    input  logic sample_tick,
    output logic press
);

    localparam int CW = $clog2(DEBOUNCE_SAMPLES + 1);

    logic [1:0]    sync_q;
    logic          level_q;
    logic [CW-1:0] count_q;
    logic          press_q;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            // Synchronizer and level start "released" so reset release alone never looks like a press.
            sync_q  <= 2'b11;
            level_q <= 1'b1;
            count_q <= '0;
            press_q <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], button_raw};
            press_q <= 1'b0;
            if (sample_tick) begin
                if (sync_q[1] == level_q) begin
                    count_q <= '0;
                end else if (count_q == CW'(DEBOUNCE_SAMPLES - 1)) begin
                    count_q <= '0;
                    level_q <= sync_q[1];
                    press_q <= ~sync_q[1];
                end else begin
                    count_q <= count_q + CW'(1);
                end
            end
        end
    end

    assign press = press_q;

endmodule

// File: rtl/pop_mode_sequencer.sv
// Steps SETUP -> POP -> DARK -> CAL on button presses, blanking all drives for a
// guard window between modes and never cutting a POP cycle short.
module pop_mode_sequencer
    import pop_timing_pkg::*;
#(
    parameter int DEBOUNCE_SAMPLES = DEBOUNCE_SAMPLES_DEFAULT,
    parameter int GUARD_CYCLES     = GUARD_CYCLES_DEFAULT
) (
    input logic                 clk,
    input logic                 reset_n,
    pop_mode_sequencer_if.slave bus
);

    localparam int GW = (GUARD_CYCLES > 1) ? $clog2(GUARD_CYCLES) : 1;

    seq_state_e    state_q, state_d;
    mode_e         mode_q, mode_d;
    logic          pending_q, pending_d;
    logic [GW-1:0] guard_q, guard_d;
    drive_t        drive_q, drive_d;
    logic          pop_en_q, pop_en_d;
    logic          press;
    logic          want_change;

    button_debouncer #(
        .DEBOUNCE_SAMPLES(DEBOUNCE_SAMPLES)
    ) u_debouncer (
        .clk        (clk),
        .reset_n    (reset_n),
        .button_raw (bus.mode_button),
        .sample_tick(bus.tick_100us),
        .press      (press)
    );

    // A press arriving together with cycle_start counts as already pending.
    assign want_change = pending_q | press;

    // NOTE: every signal gets its default first, so no path through this block can infer a latch.
    always_comb begin
        state_d   = state_q;
        mode_d    = mode_q;
        pending_d = pending_q;
        guard_d   = guard_q;
        unique case (state_q)
            ST_RUN: begin
                pending_d = want_change;
                if (want_change && (mode_q != MODE_POP || bus.cycle_start)) begin
                    state_d = ST_GUARD;
                    guard_d = '0;
                end
            end
            ST_GUARD: begin
                if (guard_q == GW'(GUARD_CYCLES - 1)) begin
                    state_d   = ST_RUN;
                    mode_d    = next_mode(mode_q);
                    pending_d = 1'b0;
                    guard_d   = '0;
                end else begin
                    guard_d = guard_q + GW'(1);
                end
            end
        endcase
    end

    always_comb begin
        drive_d  = DRIVE_OFF;
        pop_en_d = 1'b0;
        if (state_q == ST_RUN) begin
            unique case (mode_q)
                MODE_SETUP: drive_d = '{bus.slow_pulse, 1'b0, 1'b1, 1'b0, 1'b1};
                MODE_POP: begin
                    drive_d  = '{1'b1, bus.pump_in, bus.probe_in, bus.mw_in, bus.sample_in};
                    pop_en_d = 1'b1;
                end
                MODE_DARK:  drive_d = '{bus.fast_pulse, 1'b0, 1'b0, 1'b0, 1'b1};
                MODE_CAL:   drive_d = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_RUN;
            mode_q    <= MODE_SETUP;
            pending_q <= 1'b0;
            guard_q   <= '0;
            drive_q   <= DRIVE_OFF;
            pop_en_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            mode_q    <= mode_d;
            pending_q <= pending_d;
            guard_q   <= guard_d;
            drive_q   <= drive_d;
            pop_en_q  <= pop_en_d;
        end
    end

    assign bus.led_out    = drive_q.led;
    assign bus.pump_out   = drive_q.pump;
    assign bus.probe_out  = drive_q.probe;
    assign bus.mw_out     = drive_q.mw;
    assign bus.sample_out = drive_q.sample;
    assign bus.pop_enable = pop_en_q;
    assign bus.mode       = mode_q;

endmodule

// File: doc/pop_mode_sequencer.md
POP_MODE_SEQUENCER -- requirements
Module: pop_mode_sequencer

Interface
REQ-001 The block SHALL take parameter DEBOUNCE_SAMPLES, default 8, giving the number of consecutive disagreeing button samples (at tick_100us) needed to accept a new button level.
REQ-002 The block SHALL take parameter GUARD_CYCLES, default 16, giving the number of clk cycles all outputs are held low between modes.
REQ-003 Port clk, input, 1, system clock (2.5 MHz internal oscillator).
REQ-004 Port reset_n, input, 1, reset, asynchronous, active-low.
REQ-005 Port mode_button, input, 1, raw push-to-ground mode button, asynchronous to clk.
REQ-006 Port tick_100us, input, 1, single-clk debounce sample strobe.
REQ-007 Port slow_pulse, input, 1, slow LED flash source.
REQ-008 Port fast_pulse, input, 1, fast LED flash source.
REQ-009 Port cycle_start, input, 1, single-clk strobe from the POP timers marking the start of each POP cycle.
REQ-010 Ports pump_in, probe_in, mw_in, sample_in, input, 1 each, POP timer channel signals.
REQ-011 Port pop_enable, output, 1, run enable for the POP timers.
REQ-012 Ports led_out, pump_out, probe_out, mw_out, sample_out, output, 1 each, registered drive signals.
REQ-013 Port mode, output, 2, committed mode code.

Function
REQ-014 mode_button SHALL pass through a 2-flop synchronizer; the synchronized level SHALL be sampled only on clk edges where tick_100us=1.
REQ-015 Debounce: sample equal to the debounced level -> counter cleared; sample unequal -> counter+1; when counter reaches DEBOUNCE_SAMPLES, the debounced level SHALL flip and the counter SHALL clear.
REQ-016 A press event SHALL be a debounced transition from released (high) to pressed (low); release SHALL generate no event.
REQ-017 A press event SHALL set a single pending flag; further presses while pending or during guard SHALL be discarded.
REQ-018 States: RUN and GUARD; committed modes SETUP=0, POP=1, DARK=2, CAL=3.
REQ-019 RUN, mode!=POP, pending=1 -> GUARD on the next edge; RUN, mode=POP -> GUARD only on an edge where pending=1 and cycle_start=1, so no POP cycle is truncated.
REQ-020 A press event and cycle_start on the same edge in POP SHALL enter GUARD on that edge's successor, the same as an already-pending flag.
REQ-021 GUARD SHALL drive all outputs and pop_enable to 0 for exactly GUARD_CYCLES clk cycles, then commit mode=(mode+1) mod 4 (3 wraps to 0), clear pending, and return to RUN.
REQ-022 mode SHALL show the old value throughout GUARD and change on the edge that leaves GUARD.
REQ-023 RUN outputs (led,pump,probe,mw,sample): SETUP = slow_pulse,0,1,0,1; POP = 1,pump_in,probe_in,mw_in,sample_in; DARK = fast_pulse,0,0,0,1; CAL = 0,1,0,0,0.
REQ-024 All outputs SHALL be registered with 1-clk latency from their inputs; pop_enable SHALL be 1 only in RUN with mode=POP.
REQ-025 Timing: press event on edge N in a non-POP mode -> outputs low from N+2 through N+1+GUARD_CYCLES, new-mode outputs from N+2+GUARD_CYCLES.

Reset
REQ-026 While reset_n=0: all outputs and pop_enable 0, mode=SETUP, state RUN, debounced level released, counters 0, pending 0, synchronizer flops 1.
REQ-027 The first clk edge after reset_n rises SHALL drive the SETUP output values.
REQ-028 Reset asserted mid-GUARD or mid-debounce SHALL abort the operation with no mode advance.

Structure
REQ-029 Mode codes, state encoding and default parameter values SHALL live in the shared package pop_timing_pkg.
REQ-030 Synchronizer and debouncer SHALL be one sub-module, button_debouncer, which outputs a single-clk press strobe.

Verification (tick_100us every 4 clk, DEBOUNCE_SAMPLES=8, GUARD_CYCLES=16)
REQ-031 Release reset -> next edge: mode=0, probe_out=1, sample_out=1, led_out follows slow_pulse one clk late, pop_enable=0.
REQ-032 Button low for 5 ticks with 2 bounce toggles, then stable low for 8 ticks -> exactly one press event; 16 clk of all-zero outputs; mode=1 and pop_enable=1.
REQ-033 mode=1, press mid-cycle -> pump_out..sample_out keep tracking the inputs until cycle_start; GUARD starts the next edge; mode=2.
REQ-034 Three presses inside one GUARD window -> only one advance, 2->3; CAL outputs pump_out=1 and all others 0.
REQ-035 From mode=3, press -> mode wraps to 0; reset_n pulsed low at guard cycle 7 -> mode=0, no advance, SETUP outputs after release.
